// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the shared-UART arbiter.
// The master side is the environment: the requesters plus the writer's ready.
// The slave side is the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int N = 2
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic           busy;
    logic           uart_send;
    logic [7:0]     uart_data;
    logic           uart_ready;

    modport master (
        output req_valid, req_data, req_last, uart_ready,
        input  req_ack, grant, busy, uart_send, uart_data
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_ready,
        output req_ack, grant, busy, uart_send, uart_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one edge-triggered UART writer among N byte
// requesters. A message keeps the grant until its last byte. A send the
// writer fails to accept is retried. An optional idle gap follows each byte.
module uart_tx_arbiter #(
    parameter int N      = 2,
    parameter int GAP    = 0,
    parameter int ACC_TO = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W    = $clog2(N);
    localparam int ACC_W    = $clog2(ACC_TO);
    localparam int GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACC,
        S_RETRY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t           state;
    logic [N-1:0]     grant;
    logic [N-1:0]     req_ack;
    logic             lock;
    logic [IDX_W-1:0] ptr;
    logic             uart_send;
    logic [7:0]       uart_data;
    logic [ACC_W-1:0] acc_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [N-1:0]     eligible;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     sel_onehot;
    logic [7:0]       sel_byte;
    logic             sel_last;

    // While a message is locked only its owner may win; otherwise any valid requester.
    assign eligible = lock ? (bus.req_valid & grant) : bus.req_valid;

    // Round-robin search starting just after the last winner, wrapping modulo N.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        for (int k = 1; k <= N; k++) begin
            if (!sel_found && eligible[IDX_W'((int'(ptr) + k) % N)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(ptr) + k) % N);
            end
        end
    end

    // Decode the winner into a one-hot vector and pick its byte.
    always_comb begin
        sel_byte   = '0;
        sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_byte      = bus.req_data[8*i +: 8];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_last = bus.req_last[sel_idx];

    // Arbitration and send/ready sequencing; every output here is a register.
    // NOTE: non-blocking assignments keep all state updates on one edge consistent.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            grant     <= '0;
            req_ack   <= '0;
            lock      <= 1'b0;
            ptr       <= IDX_W'(N - 1);
            uart_send <= 1'b0;
            uart_data <= '0;
            acc_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            // The ack is a single-cycle pulse; it is only raised again on a new grant.
            req_ack <= '0;
            unique case (state)
                S_IDLE: begin
                    if (bus.uart_ready && sel_found) begin
                        uart_data <= sel_byte;
                        req_ack   <= sel_onehot;
                        grant     <= sel_onehot;
                        ptr       <= sel_idx;
                        lock      <= ~sel_last;
                        uart_send <= 1'b1;
                        acc_cnt   <= '0;
                        state     <= S_WAIT_ACC;
                    end
                end
                S_WAIT_ACC: begin
                    if (!bus.uart_ready) begin
                        uart_send <= 1'b0;
                        state     <= S_WAIT_DONE;
                    end else if (acc_cnt == ACC_W'(ACC_TO - 1)) begin
                        uart_send <= 1'b0;
                        state     <= S_RETRY;
                    end else begin
                        acc_cnt <= acc_cnt + ACC_W'(1);
                    end
                end
                S_RETRY: begin
                    // One low cycle has passed, so raising send again is a fresh edge.
                    uart_send <= 1'b1;
                    acc_cnt   <= '0;
                    state     <= S_WAIT_ACC;
                end
                S_WAIT_DONE: begin
                    if (bus.uart_ready) begin
                        if (!lock) begin
                            grant <= '0;
                        end
                        if (GAP > 0) begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack   = req_ack;
    assign bus.grant     = grant;
    assign bus.busy      = (state != S_IDLE);
    assign bus.uart_send = uart_send;
    assign bus.uart_data = uart_data;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `UART_WriteD` transmitter among `N` byte-stream requesters (alarm event reporter, console echo, debug dump). Each requester offers bytes on a valid/ack handshake. The arbiter grants round-robin with message locking, sequences the transmitter's edge-triggered `send`/`ready` protocol, retries a send the transmitter fails to accept, and enforces an optional inter-byte gap.

## Interface
- `N`, default 2: number of requesters, legal range 2..4.
- `GAP`, default 0: idle clock cycles inserted after each completed byte.
- `ACC_TO`, default 8: cycles to wait for the transmitter to accept before retrying. Minimum 3.

Ports:
- `Clock`  in  1  system clock; all state updates on posedge.
- `Reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  requester i has a byte pending.
- `req_data`  in  8*N  byte for requester i at bits [8i+7:8i].
- `req_last`  in  N  byte is the last of a message; releases the lock.
- `req_ack`  out  N  one-cycle pulse when requester i's byte is latched.
- `grant`  out  N  one-hot owner of the transmitter; 0 when unowned.
- `busy`  out  1  high in any state other than S_IDLE.
- `uart_send`  out  1  drives the writer's `send`.
- `uart_data`  out  8  drives the writer's `data`.
- `uart_ready`  in  1  the writer's `ready`.

## Operation
- Protocol requirements:
  - The requester holds `req_valid`, `req_data` and `req_last` stable until its `req_ack`.
  - The writer launches a byte on a rising edge of `send` and holds `ready` low while shifting.
- States: S_IDLE, S_WAIT_ACC, S_RETRY, S_WAIT_DONE, S_GAP.
- **Eligibility in S_IDLE:**
  - If `lock`=1, only the requester recorded in `grant` is eligible.
  - Otherwise, every requester with `req_valid` is eligible, searched from `ptr+1` upward with wrap-around modulo N.
- **S_IDLE → S_WAIT_ACC.** Taken when `uart_ready`=1 and at least one requester is eligible. The first eligible requester g is selected, and on the same edge:
  - `uart_data` <= that requester's byte
  - `req_ack[g]` <= 1 for one cycle
  - `grant` <= onehot(g)
  - `ptr` <= g
  - `lock` <= ~`req_last[g]`
  - `uart_send` <= 1
  - the timeout counter clears
- **S_WAIT_ACC.**
  - If `uart_ready`=0: `uart_send` <= 0, go to S_WAIT_DONE.
  - Else, if the counter reaches `ACC_TO`-1: `uart_send` <= 0, go to S_RETRY.
- **S_RETRY.** Lasts exactly one cycle with `uart_send` low. Then `uart_send` <= 1, the counter clears, and the state returns to S_WAIT_ACC. The same byte is resent and no new ack is issued. Retries are unbounded.
- **S_WAIT_DONE.** On `uart_ready`=1:
  - go to S_GAP if `GAP`>0, else to S_IDLE;
  - in either case, `grant` clears if `lock`=0.
- **S_GAP.** Counts `GAP` cycles, then goes to S_IDLE.
- **Locked requester drops valid.** The arbiter waits in S_IDLE indefinitely; other requesters are blocked until a byte with `req_last`=1 is sent.
- **Reset values.** Any time `Reset` is low:
  - state = S_IDLE
  - `uart_send`=0, `uart_data`=0, `req_ack`=0, `grant`=0, `busy`=0
  - `lock`=0
  - `ptr`=N-1, so requester 0 wins first
- A reset mid-transfer abandons the byte. No ack is reissued.
- Counters are sized by $clog2 of `ACC_TO` and `GAP`+1. Counters saturate and never wrap.

## Timing
- From `req_valid` seen in S_IDLE, `req_ack` and `uart_send` rise on the next edge (latency 1).
- The writer samples `send` on negedge and `ready` falls about 1–2 cycles later. `uart_send` therefore stays high for at least 2 cycles, which guarantees a clean rising edge.
- Back-to-back bytes: the earliest new grant is the first S_IDLE cycle after `uart_ready` returns high, plus `GAP` cycles.
- At most one `req_ack` bit is high in any cycle.
- `grant` never changes while in S_WAIT_ACC, S_RETRY or S_WAIT_DONE.
- Simultaneous requests resolve by round-robin only. There is no fixed priority except immediately after reset.

## Test plan
- **Single byte.** Requester 0 sends 0x41 with last=1.
  - One `req_ack[0]` pulse; `uart_data`=0x41.
  - TX shows frame 0x41 and `uart_send` falls once `ready` drops.
  - `grant` returns to 0 and `busy` falls after ready rises.
- **Round-robin.** Requesters 0 and 1 hold valid continuously, bytes 0xA0 and 0xB1, last=1.
  - Acks alternate 0,1,0,1 starting with requester 0 after reset.
  - TX byte order is A0, B1, A0, B1.
- **Message lock.** Requester 1 sends a 3-byte message 0x10, 0x11, 0x12 (last only on 0x12) while requester 0 holds valid.
  - The three bytes are contiguous.
  - Requester 0 is acked only after 0x12.
- **Accept timeout.** With `ACC_TO`=4, the bench model holds `ready` high and ignores the first `send`.
  - After 4 cycles: `uart_send` low for exactly 1 cycle, then high again.
  - The byte completes on the second attempt with a single ack.
- **Gap.** With `GAP`=5 and two queued bytes, exactly 5 cycles separate `ready` rising from the next `uart_send` rising, measured from S_IDLE entry.
- **Reset mid-transfer.** Assert `Reset` low during S_WAIT_DONE.
  - All outputs go to 0 asynchronously.
  - After release, requester 0 wins first and no stale ack appears.
